// File: rtl/pwm_duty_decoder_pkg.sv
// Shared types and constants for the PWM duty decoder and the PWM generator.
package pwm_duty_decoder_pkg;

  // Decoder measurement phases.
  typedef enum logic [1:0] {
    SYNC = 2'd0,  // waiting for a rising edge to start a measurement
    HIGH = 2'd1,  // counting high time
    LOW  = 2'd2   // counting low time
  } state_e;

  localparam int DUTY_W        = 7;
  localparam int DUTY_MAX      = (1 << DUTY_W) - 1;
  // Duty reported for a constant-high input; the generator uses the same scale.
  localparam int PWM_FULL_DUTY = 100;

endpackage

// File: rtl/pwm_duty_decoder_edge_sync.sv
// pwm_edge_sync: 2-flop synchronizer, optional 3-sample majority filter and
// rise/fall edge detection for the asynchronous PWM pin.
// Optional feature macro: PWM_DEC_GLITCH_FILTER_EN (adds the majority filter,
// raising pin-to-strobe latency from 3 to 5 cycles).
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,    // synchronous, active high
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int DEPTH = 6;
`else
  localparam int DEPTH = 3;
`endif

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [2:0] fill_q;
  logic       filt_level;
  logic       primed;

  // Two-flop synchronizer on the raw pin.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= pwm_i;
      sync_q <= meta_q;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       maj_q;

  // Majority of the last three synchronized samples rejects 1-cycle glitches.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      hist_q <= 2'b00;
      maj_q  <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_q};
      maj_q  <= (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign filt_level = maj_q;
`else
  assign filt_level = sync_q;
`endif

  // Previous level for edge detection, plus a fill counter that holds edges off
  // until every stage carries a real pin sample (a high pin at reset release is not an edge).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      prev_q <= 1'b0;
      fill_q <= '0;
    end else begin
      prev_q <= filt_level;
      if (!primed) fill_q <= fill_q + 3'd1;
    end
  end

  assign primed  = (fill_q == 3'(DEPTH));
  assign level_o = filt_level;
  assign rise_o  = primed &  filt_level & ~prev_q;
  assign fall_o  = primed & ~filt_level &  prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high time and period of a PWM input in clk cycles,
// pulses valid per completed period, and flags a stuck input after TIMEOUT
// edgeless cycles. Optional feature macro: PWM_DEC_GLITCH_FILTER_EN (in pwm_edge_sync).
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int FULL_DUTY = PWM_FULL_DUTY,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,   // synchronous, active high
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic              valid,
  output logic              stuck
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic level, rise, fall, any_edge;

  pwm_edge_sync u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_i   (pwm_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   hi_q,     hi_d;
  logic [CNT_W-1:0]   lo_q,     lo_d;
  logic [TMO_W-1:0]   tmo_q,    tmo_d;
  logic [DUTY_W-1:0]  duty_q,   duty_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               valid_q,  valid_d;
  logic               stuck_q,  stuck_d;

  logic [CNT_W-1:0]   hi_inc, lo_inc, period_sat;
  logic [CNT_W:0]     sum;
  logic [DUTY_W-1:0]  duty_sat;

  // Saturating increments and the saturated duty/period of the current measurement.
  always_comb begin
    hi_inc     = (hi_q == '1) ? hi_q : hi_q + CNT_W'(1);
    lo_inc     = (lo_q == '1) ? lo_q : lo_q + CNT_W'(1);
    sum        = {1'b0, hi_q} + {1'b0, lo_q};
    period_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    duty_sat   = (32'(hi_q) > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : DUTY_W'(hi_q);
  end

  assign any_edge = rise | fall;

  // Next-state logic: phase tracking, counters, result capture and stuck timeout.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmo_d    = tmo_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;

    if (any_edge) begin
      tmo_d   = '0;
      stuck_d = 1'b0;
    end else if (!stuck_q) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      SYNC: begin
        if (rise) begin
          state_d = HIGH;
          hi_d    = CNT_W'(1);
          lo_d    = '0;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          lo_d    = CNT_W'(1);
        end else begin
          hi_d = hi_inc;
        end
      end
      LOW: begin
        if (rise) begin
          duty_d   = duty_sat;
          period_d = period_sat;
          valid_d  = 1'b1;
          state_d  = HIGH;
          hi_d     = CNT_W'(1);
          lo_d     = '0;
        end else begin
          lo_d = lo_inc;
        end
      end
      default: state_d = SYNC;
    endcase

    // TIMEOUT consecutive cycles without an edge: report a flat line and resync.
    if (!any_edge && !stuck_q && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
      stuck_d  = 1'b1;
      duty_d   = level ? DUTY_W'(FULL_DUTY) : '0;
      period_d = '0;
      valid_d  = 1'b1;
      state_d  = SYNC;
      hi_d     = '0;
      lo_d     = '0;
      tmo_d    = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= SYNC;
      hi_q     <= '0;
      lo_q     <= '0;
      tmo_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmo_q    <= tmo_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;

endmodule

// File: doc/pwm_duty_decoder.md
PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the counter and period width in bits.
REQ-002 The block SHALL have parameter FULL_DUTY, default 100, giving the duty value reported for a constant-high input.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the number of cycles without an edge before the stuck state is declared.
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous active-high reset, with the same polarity as the pwm core's rst_n port.
REQ-006 Port pwm_in, input, 1 bit: asynchronous PWM waveform to be decoded.
REQ-007 Port duty, output, 7 bits: high-time of the last completed period in clk cycles, saturated at 127.
REQ-008 Port period, output, CNT_W bits: total length of the last completed period in clk cycles, saturated at all-ones.
REQ-009 Port valid, output, 1 bit: one-cycle pulse that fires when duty and period update.
REQ-010 Port stuck, output, 1 bit: level, high while no edge has occurred for TIMEOUT cycles.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer; rising and falling edges SHALL be detected on the synchronized signal, giving 3 cycles from a pin edge to the edge strobe.
REQ-012 The state machine SHALL have three states:
- SYNC: waiting for the first rising edge after reset or after stuck.
- HIGH: counting high time.
- LOW: counting low time.
REQ-013 In SYNC, a rising edge SHALL move the block to HIGH with hi_cnt=1 and lo_cnt=0; no valid pulse is produced for that first edge.
REQ-014 In HIGH, each cycle SHALL increment hi_cnt, and a falling edge SHALL move the block to LOW with lo_cnt=1.
REQ-015 In LOW, each cycle SHALL increment lo_cnt.
REQ-016 A rising edge in LOW SHALL do all of the following in the same cycle:
- register duty=min(hi_cnt,127) and period=sat(hi_cnt+lo_cnt);
- pulse valid for 1 cycle;
- return to HIGH with hi_cnt=1 and lo_cnt=0.
REQ-017 hi_cnt and lo_cnt SHALL saturate at all-ones and never wrap; the period sum SHALL be computed at CNT_W+1 bits and then saturated.
REQ-018 A cycle counter SHALL clear on every edge; when it reaches TIMEOUT, the block SHALL do all of the following:
- set stuck=1;
- set duty to FULL_DUTY if the input is high, or 0 if it is low;
- set period to 0;
- pulse valid once;
- enter SYNC.
REQ-019 stuck SHALL clear on the next detected edge of either polarity; that edge SHALL NOT produce a valid pulse.
REQ-020 A falling edge while in SYNC SHALL be ignored, apart from clearing stuck.
REQ-021 duty and period SHALL hold their values between valid pulses.

Reset
REQ-022 When rst_n=1 at a clk edge, the block SHALL force SYNC state, zero all counters and synchronizer flops, and set duty=0, period=0, valid=0, stuck=0.
REQ-023 A reset asserted mid-period SHALL discard the partial measurement; the first valid pulse after reset SHALL come on the second rising edge.

Configuration
REQ-024 With PWM_DEC_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL follow the synchronizer, so single-cycle glitches are rejected and edge latency becomes 5 cycles.
REQ-025 Without PWM_DEC_GLITCH_FILTER_EN, the filter SHALL be absent, every edge SHALL be honoured, and latency SHALL be 3 cycles.

Structure
REQ-026 A shared package SHALL hold:
- the state enum (SYNC, HIGH, LOW);
- the DUTY_W=7 constant;
- the default FULL_DUTY constant, shared with the pwm generator.
REQ-027 The synchronizer, optional filter and edge detect SHALL form one sub-module, pwm_edge_sync, with outputs for the synchronized level, rise strobe and fall strobe.

Verification
REQ-028 Period-100, duty-30 waveform for 5 periods: no valid pulse on the first rising edge, then 4 valid pulses with duty=30 and period=100 each.
REQ-029 pwm_in held high for 300 cycles after one period: stuck=1 and a valid pulse with duty=100 and period=0 at TIMEOUT; then a falling edge clears stuck with no valid pulse.
REQ-030 High time of 200 cycles in one period:
- With the default configuration, duty=127 and period=255 (saturated).
- With CNT_W=9, period is exact.
REQ-031 Reset asserted for 1 cycle in the middle of a high phase: outputs go to 0 and state to SYNC; the next valid pulse appears on the second rising edge after reset.
REQ-032 A 1-cycle low glitch inside a 40-cycle high phase:
- With PWM_DEC_GLITCH_FILTER_EN, duty=40.
- Without it, duty equals the glitch-split high count.
REQ-033 Duty of 1 cycle high with period 100: duty=1 and period=100, with no missed edges.
